softmax_row: RTL and testbench



---
 rtl/softmax_row.sv | 217 +++++++++++++++++++++
 tb/tb_softmax_row.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/softmax_row.sv
// softmax_row: row-wise integer softmax over the int8 QK score matrices.
// Each row (32 signed int8 scores packed in 4 x 64-bit words) is read, the
// row maximum m is tracked, exp2 is approximated with a 4-entry LUT plus a
// right shift, the 13-bit row sum is inverted by a 22-step restoring divide
// (recip = floor(2^21 / sum)), and every lane is scaled to an unsigned 8-bit
// probability (scale 256) and written back one word per cycle.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start, done         run trigger (sampled in IDLE) / end-of-run pulse
//   *_bar0              score port: read-only, addr_bar0 -> data_out_bar0
//                       with one cycle of latency
//   *_bar1              probability port: write_en_bar1/addr_bar1/data_in_bar1
//                       commit at the rising edge ending the WRITE cycle
module softmax_row #(
    parameter int WIDTH               = 64,
    parameter int HEADS               = 4,
    parameter int SEQ                 = 32,
    parameter int QKMM_OUTPUT_BASE    = 512,
    parameter int SOFTMAX_OUTPUT_BASE = 2560
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             done,
    output logic             write_en_bar0,
    output logic [WIDTH-1:0] data_in_bar0,
    output logic [31:0]      addr_bar0,
    input  logic [WIDTH-1:0] data_out_bar0,
    output logic             write_en_bar1,
    output logic [WIDTH-1:0] data_in_bar1,
    output logic [31:0]      addr_bar1,
    input  logic [WIDTH-1:0] data_out_bar1
);
    localparam int LANES = WIDTH / 8;
    localparam int WPR   = SEQ / LANES;    // words per row
    localparam int ROWS  = HEADS * SEQ;
    localparam int ROW_W = $clog2(ROWS);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_EXP   = 3'd2;
    localparam logic [2:0] S_DIV   = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]                  state_reg;
    logic [4:0]                  cnt_reg;
    logic [ROW_W-1:0]            row_reg;
    logic signed [7:0]           m_reg;
    logic [12:0]                 sum_reg;
    logic [21:0]                 quo_reg;
    logic [12:0]                 rem_reg;
    logic [31:0]                 addr0_reg;
    logic [WPR-1:0][WIDTH-1:0]   buf_reg;

    logic                        unused_bar1;
    assign unused_bar1 = ^data_out_bar1;

    assign write_en_bar0 = 1'b0;
    assign data_in_bar0  = '0;
    assign done          = (state_reg == S_DONE);
    assign write_en_bar1 = (state_reg == S_WRITE);

    // Word k of the current row sits at row*WPR + k from either base.
    logic [31:0] row_off;
    logic [31:0] rd_addr;
    logic        rd_issue;
    assign row_off  = 32'(row_reg) * 32'(WPR);
    assign rd_addr  = 32'(QKMM_OUTPUT_BASE) + row_off + 32'(cnt_reg[1:0]);
    assign rd_issue = (state_reg == S_READ) && (cnt_reg < 5'd4);
    // Live address while issuing, otherwise hold the last one issued.
    assign addr_bar0 = rd_issue ? rd_addr : addr0_reg;
    assign addr_bar1 = 32'(SOFTMAX_OUTPUT_BASE) + row_off + 32'(cnt_reg[1:0]);

    // Running signed maximum including the word arriving this cycle.
    logic signed [7:0] word_max;
    always_comb begin
        word_max = m_reg;
        for (int j = 0; j < LANES; j++) begin
            if ($signed(data_out_bar0[WIDTH-1-8*j -: 8]) > word_max)
                word_max = data_out_bar0[WIDTH-1-8*j -: 8];
        end
    end

    // Per-lane exp2 and output scaling on the buffer word selected by cnt.
    logic [WIDTH-1:0] cur_word;
    logic [WIDTH-1:0] exp_word;
    logic [WIDTH-1:0] wr_word;
    logic [7:0]       exp_lane [LANES];
    logic [13:0]      recip;
    assign cur_word = buf_reg[cnt_reg[1:0]];
    assign recip    = quo_reg[13:0];

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [7:0]  x;
        logic [8:0]  d;
        logic [7:0]  lut;
        logic [7:0]  e;
        logic [21:0] prod;
        assign x = cur_word[WIDTH-1-8*gi -: 8];
        // m >= x always holds, so the 9-bit difference is in 0..255.
        assign d = {m_reg[7], m_reg} - {x[7], x};
        always_comb begin
            case (d[1:0])
                2'd0:    lut = 8'd255;
                2'd1:    lut = 8'd214;
                2'd2:    lut = 8'd180;
                default: lut = 8'd151;
            endcase
        end
        // Shift amount d[8:2] of 8 or more flushes the value to zero.
        assign e = (d[8:5] != 4'd0) ? 8'd0 : (lut >> d[4:2]);
        assign exp_word[WIDTH-1-8*gi -: 8] = e;
        assign exp_lane[gi] = e;
        // In WRITE the lane already holds e; saturate the >>13 result at 255.
        assign prod = 22'(x) * 22'(recip);
        assign wr_word[WIDTH-1-8*gi -: 8] = prod[21] ? 8'hFF : prod[20:13];
    end

    assign data_in_bar1 = wr_word;

    logic [10:0] exp_sum;
    always_comb begin
        exp_sum = '0;
        for (int j = 0; j < LANES; j++)
            exp_sum = exp_sum + 11'(exp_lane[j]);
    end

    // One restoring-divide step: shift in the next dividend bit from the
    // top of the quotient register, subtract the divisor when it fits.
    logic [13:0] trial;
    logic        fits;
    assign trial = {rem_reg, quo_reg[21]};
    assign fits  = (trial >= {1'b0, sum_reg});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            row_reg   <= '0;
            m_reg     <= -8'sd128;
            sum_reg   <= '0;
            quo_reg   <= '0;
            rem_reg   <= '0;
            addr0_reg <= 32'(QKMM_OUTPUT_BASE);
            buf_reg   <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_reg <= S_READ;
                        cnt_reg   <= '0;
                        m_reg     <= -8'sd128;
                    end
                end
                S_READ: begin
                    if (rd_issue)
                        addr0_reg <= rd_addr;
                    if (cnt_reg != 5'd0) begin
                        buf_reg[cnt_reg[1:0] - 2'd1] <= data_out_bar0;
                        m_reg <= word_max;
                    end
                    if (cnt_reg == 5'd4) begin
                        state_reg <= S_EXP;
                        cnt_reg   <= '0;
                        sum_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 5'd1;
                    end
                end
                S_EXP: begin
                    buf_reg[cnt_reg[1:0]] <= exp_word;
                    sum_reg <= sum_reg + 13'(exp_sum);
                    if (cnt_reg == 5'd3) begin
                        state_reg <= S_DIV;
                        cnt_reg   <= '0;
                        quo_reg   <= 22'h200000;   // dividend 2^21
                        rem_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 5'd1;
                    end
                end
                S_DIV: begin
                    quo_reg <= {quo_reg[20:0], fits};
                    rem_reg <= fits ? 13'(trial - {1'b0, sum_reg}) : trial[12:0];
                    if (cnt_reg == 5'd21) begin
                        state_reg <= S_WRITE;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 5'd1;
                    end
                end
                S_WRITE: begin
                    if (cnt_reg == 5'd3) begin
                        cnt_reg <= '0;
                        row_reg <= row_reg + 1'b1;
                        if (row_reg == ROW_W'(ROWS - 1)) begin
                            state_reg <= S_DONE;
                        end else begin
                            state_reg <= S_READ;
                            m_reg     <= -8'sd128;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 5'd1;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_softmax_row.sv
// tb_softmax_row: drives softmax_row against a bench-side score memory and
// compares every probability write with a row-level softmax model computed
// from plain integer arithmetic. Directed rows 0..3 are also pinned to
// hand-computed words.
module tb_softmax_row;
    localparam int QB = 512;
    localparam int SB = 2560;
    localparam int NW = 512;
    localparam int RUN_CYCLES = 4490;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        done;
    logic        write_en_bar0;
    logic [63:0] data_in_bar0;
    logic [31:0] addr_bar0;
    logic [63:0] data_out_bar0;
    logic        write_en_bar1;
    logic [63:0] data_in_bar1;
    logic [31:0] addr_bar1;
    logic [63:0] data_out_bar1;

    softmax_row dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .done          (done),
        .write_en_bar0 (write_en_bar0),
        .data_in_bar0  (data_in_bar0),
        .addr_bar0     (addr_bar0),
        .data_out_bar0 (data_out_bar0),
        .write_en_bar1 (write_en_bar1),
        .data_in_bar1  (data_in_bar1),
        .addr_bar1     (addr_bar1),
        .data_out_bar1 (data_out_bar1)
    );

    always #5 clk = ~clk;

    // Score memory with one cycle of read latency.
    logic [63:0] mem     [NW];
    logic [63:0] exp_mem [NW];
    logic [63:0] dut_out [NW];
    logic [8:0]  rd_idx;
    logic [63:0] rd_q;
    assign rd_idx        = 9'(addr_bar0 - 32'(QB));
    assign data_out_bar0 = rd_q;
    assign data_out_bar1 = 64'hA5A5_5A5A_C3C3_3C3C;
    always @(posedge clk) rd_q <= mem[rd_idx];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int start_cyc = 0;
    int wr_n = 0;
    int done_cnt = 0;
    bit mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // exp2 approximation from the LUT/shift rule.
    function automatic int exp2i(input int d);
        int v;
        if (d >= 32) return 0;
        case (d % 4)
            0:       v = 255;
            1:       v = 214;
            2:       v = 180;
            default: v = 151;
        endcase
        return v >> (d / 4);
    endfunction

    task automatic set_elem(input int row, input int idx, input int val);
        int w;
        int lane;
        w    = row * 4 + idx / 8;
        lane = idx % 8;
        mem[w][63-8*lane -: 8] = 8'(val);
    endtask

    task automatic fill_scores();
        int mode;
        int base;
        int v;
        for (int i = 0; i < 32; i++) begin
            set_elem(0, i, 5);
            set_elem(1, i, (i == 21) ? 127 : -128);
            set_elem(2, i, (i == 0) ? 0 : -4);
            case (i)
                0:       set_elem(3, i, 100);
                1:       set_elem(3, i, 99);
                2:       set_elem(3, i, 98);
                3:       set_elem(3, i, 97);
                default: set_elem(3, i, -128);
            endcase
        end
        for (int r = 4; r < 128; r++) begin
            mode = int'($urandom_range(0, 2));
            base = int'($urandom_range(0, 255)) - 128;
            for (int i = 0; i < 32; i++) begin
                if (mode == 0) v = int'($urandom_range(0, 255)) - 128;
                else if (mode == 1) v = base + int'($urandom_range(0, 12));
                else v = base + int'($urandom_range(0, 40));
                if (v > 127) v = 127;
                set_elem(r, i, v);
            end
        end
    endtask

    task automatic build_model();
        int s [32];
        int e [32];
        int m;
        int sum;
        int recip;
        int p;
        logic [7:0] b;
        for (int r = 0; r < 128; r++) begin
            m = -128;
            for (int i = 0; i < 32; i++) begin
                b = mem[r*4 + i/8][63-8*(i%8) -: 8];
                s[i] = int'($signed(b));
                if (s[i] > m) m = s[i];
            end
            sum = 0;
            for (int i = 0; i < 32; i++) begin
                e[i] = exp2i(m - s[i]);
                sum += e[i];
            end
            recip = 2097152 / sum;
            for (int i = 0; i < 32; i++) begin
                p = (e[i] * recip) >> 13;
                if (p > 255) p = 255;
                exp_mem[r*4 + i/8][63-8*(i%8) -: 8] = 8'(p);
            end
        end
    endtask

    // Hand-computed words for the four directed rows.
    function automatic logic [63:0] lit_word(input int row, input int k);
        case (row)
            0:       return 64'h0707_0707_0707_0707;
            1:       return (k == 2) ? 64'h0000_0000_00FF_0000 : 64'h0;
            2:       return (k == 0) ? 64'h0F07_0707_0707_0707 : 64'h0707_0707_0707_0707;
            default: return (k == 0) ? 64'h5144_3930_0000_0000 : 64'h0;
        endcase
    endfunction

    // Per-cycle observation at the falling edge.
    task automatic observe();
        check("bar0_tied", {63'(data_in_bar0 != 64'h0), write_en_bar0}, 64'h0);
        if (!mon_en) begin
            wr_n     = 0;
            done_cnt = 0;
        end else begin
            if (write_en_bar1) begin
                if (wr_n >= NW) begin
                    check("extra_write", 64'(wr_n), 64'(NW - 1));
                end else begin
                    $display("write %0d: addr %0d data %h", wr_n, addr_bar1, data_in_bar1);
                    check("wr_addr", 64'(addr_bar1), 64'(SB + wr_n));
                    check("wr_data", data_in_bar1, exp_mem[wr_n]);
                    dut_out[wr_n] = data_in_bar1;
                end
                wr_n++;
            end
            if (done) begin
                done_cnt++;
                $display("done at run cycle %0d", cyc - start_cyc);
                check("done_cycle", 64'(cyc - start_cyc), 64'd4481);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        observe();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_done"}, 64'(done), 64'h0);
        check({tag, "_we1"}, 64'(write_en_bar1), 64'h0);
        check({tag, "_addr0"}, 64'(addr_bar0), 64'(QB));
        check({tag, "_addr1"}, 64'(addr_bar1), 64'(SB));
        check({tag, "_din1"}, data_in_bar1, 64'h0);
    endtask

    // Full run from IDLE; optionally pulse start mid-run (must be ignored).
    task automatic do_run(input bit mid_start);
        mon_en    = 1'b1;
        start     = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
        for (int i = 1; i < RUN_CYCLES; i++) begin
            tick();
            if (mid_start && i == 2000) start = 1'b1;
            else start = 1'b0;
        end
        check("write_count", 64'(wr_n), 64'(NW));
        check("done_count", 64'(done_cnt), 64'd1);
        mon_en = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < NW; i++) begin
            mem[i]     = '0;
            dut_out[i] = '0;
        end
        tick();
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();
        check("post_reset_no_write", 64'(write_en_bar1), 64'h0);

        // Run 1: directed rows 0..3 plus random rows.
        fill_scores();
        build_model();
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                check("model_pin", exp_mem[r*4 + k], lit_word(r, k));
            end
        end
        do_run(1'b0);
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                check("dut_pin", dut_out[r*4 + k], lit_word(r, k));
            end
        end

        // Run 2: new random scores, abort with reset at cycle 1000, restart.
        fill_scores();
        build_model();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 1000; i++) tick();
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        tick();
        tick();
        tick();
        check_reset_outputs("midrst_hold");
        rst = 1'b0;
        tick();
        check("midrst_no_write", 64'(write_en_bar1), 64'h0);
        check("midrst_no_done", 64'(done), 64'h0);
        do_run(1'b1);
        for (int r = 0; r < 4; r++) begin
            check("dut_pin_rerun", dut_out[r*4], lit_word(r, 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
